// File: rtl/rregs_stage.sv
// rregs_stage: one WIDTH-bit register with async active-low reset to RESET_VAL,
// synchronous clear (wins over enable), and load enable.
module rregs_stage #(
   parameter int               WIDTH     = 1,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   // reset > clear > load > hold
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)   q <= RESET_VAL;
      else if (clr) q <= RESET_VAL;
      else if (en)  q <= d;
   end

endmodule

// File: rtl/rregs_pipe.sv
// rregs_pipe: DEPTH-stage tapped register chain with a parallel valid chain.
// Data shifts whenever enabled regardless of valid; valid only labels each stage.
module rregs_pipe #(
   parameter int               WIDTH     = 1,
   parameter int               DEPTH     = 1,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic                         eph1,
   input  logic                         reset,
   input  logic                         en,
   input  logic                         flush,
   input  logic [WIDTH-1:0]             d,
   input  logic                         vld_in,
   output logic [WIDTH-1:0]             q,
   output logic [DEPTH*WIDTH-1:0]       taps,
   output logic                         vld_out,
   output logic [$clog2(DEPTH+1)-1:0]   vld_count,
   output logic                         full
);

   localparam int CW = $clog2(DEPTH+1);

   if (DEPTH < 1) begin : g_bad_depth
      $error("rregs_pipe: DEPTH must be >= 1");
   end

   // number of set bits in the valid vector
   function automatic logic [CW-1:0] popcount(input logic [DEPTH-1:0] v);
      logic [CW-1:0] c;
      c = '0;
      for (int i = 0; i < DEPTH; i++) c = c + CW'(v[i]);
      return c;
   endfunction

   logic [DEPTH-1:0][WIDTH-1:0] stage;
   logic [DEPTH-1:0][WIDTH-1:0] stage_d;
   logic [DEPTH-1:0]            vld;
   logic [DEPTH-1:0]            vld_d;

   for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      if (i == 0) begin : g_head
         assign stage_d[i] = d;
         assign vld_d[i]   = vld_in;
      end else begin : g_body
         assign stage_d[i] = stage[i-1];
         assign vld_d[i]   = vld[i-1];
      end

      rregs_stage #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_data (
         .clk   (eph1),
         .rst_n (reset),
         .clr   (flush),
         .en    (en),
         .d     (stage_d[i]),
         .q     (stage[i])
      );

      rregs_stage #(.WIDTH(1), .RESET_VAL(1'b0)) u_vld (
         .clk   (eph1),
         .rst_n (reset),
         .clr   (flush),
         .en    (en),
         .d     (vld_d[i]),
         .q     (vld[i])
      );
   end

   // packed layout already puts stage 0 in the least significant slot
   assign taps      = stage;
   assign q         = stage[DEPTH-1];
   assign vld_out   = vld[DEPTH-1];
   assign vld_count = popcount(vld);
   assign full      = (vld_count == CW'(DEPTH));

endmodule

// File: tb/tb_rregs_pipe.sv
// tb_rregs_pipe: three configurations (8x4 with nonzero reset value, 8x1, 128x12)
// driven from shared controls and compared against an array-shift reference model.
module tb_rregs_pipe;

   logic         eph1 = 1'b0;
   logic         reset, en, flush, vld_in;
   logic [7:0]   d8;
   logic [127:0] d128;

   logic [7:0]    q4, q1;
   logic [127:0]  q12;
   logic [31:0]   taps4;
   logic [7:0]    taps1;
   logic [1535:0] taps12;
   logic          vo4, vo1, vo12, full4, full1, full12;
   logic [2:0]    vc4;
   logic [0:0]    vc1;
   logic [3:0]    vc12;

   int errors = 0;
   int checks = 0;

   always #5 eph1 = ~eph1;

   rregs_pipe #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'h3C)) u_d4 (
      .eph1(eph1), .reset(reset), .en(en), .flush(flush), .d(d8), .vld_in(vld_in),
      .q(q4), .taps(taps4), .vld_out(vo4), .vld_count(vc4), .full(full4));

   rregs_pipe #(.WIDTH(8), .DEPTH(1)) u_d1 (
      .eph1(eph1), .reset(reset), .en(en), .flush(flush), .d(d8), .vld_in(vld_in),
      .q(q1), .taps(taps1), .vld_out(vo1), .vld_count(vc1), .full(full1));

   rregs_pipe #(.WIDTH(128), .DEPTH(12)) u_w12 (
      .eph1(eph1), .reset(reset), .en(en), .flush(flush), .d(d128), .vld_in(vld_in),
      .q(q12), .taps(taps12), .vld_out(vo12), .vld_count(vc12), .full(full12));

   // reference model: md[k][i] is stage i of instance k
   int           dep [3] = '{4, 1, 12};
   logic [127:0] rv  [3] = '{128'h3C, 128'h0, 128'h0};
   logic [127:0] md  [3][12];
   bit           mv  [3][12];

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      for (int k = 0; k < 3; k++)
         for (int i = 0; i < 12; i++) begin
            md[k][i] = rv[k];
            mv[k][i] = 1'b0;
         end
   endtask

   task automatic model_edge();
      if (!reset || flush) model_clear();
      else if (en) begin
         for (int k = 0; k < 3; k++) begin
            for (int i = dep[k]-1; i >= 1; i--) begin
               md[k][i] = md[k][i-1];
               mv[k][i] = mv[k][i-1];
            end
            md[k][0] = (k == 2) ? d128 : {120'b0, d8};
            mv[k][0] = vld_in;
         end
      end
   endtask

   function automatic logic [127:0] obs_stage(input int k, input int i);
      case (k)
         0:       return {120'b0, taps4[i*8 +: 8]};
         1:       return {120'b0, taps1};
         default: return taps12[i*128 +: 128];
      endcase
   endfunction

   task automatic check_all(input string tag);
      int cnt;
      logic [127:0] oq, oc;
      logic ov, of;
      for (int k = 0; k < 3; k++) begin
         cnt = 0;
         for (int i = 0; i < dep[k]; i++) begin
            chk($sformatf("%s_k%0d_tap%0d", tag, k, i), obs_stage(k, i), md[k][i]);
            cnt += int'(mv[k][i]);
         end
         case (k)
            0:       begin oq = {120'b0, q4}; ov = vo4;  oc = {125'b0, vc4};  of = full4;  end
            1:       begin oq = {120'b0, q1}; ov = vo1;  oc = {127'b0, vc1};  of = full1;  end
            default: begin oq = q12;          ov = vo12; oc = {124'b0, vc12}; of = full12; end
         endcase
         chk($sformatf("%s_k%0d_q", tag, k), oq, md[k][dep[k]-1]);
         chk($sformatf("%s_k%0d_vld_out", tag, k), {127'b0, ov}, {127'b0, mv[k][dep[k]-1]});
         chk($sformatf("%s_k%0d_vld_count", tag, k), oc, 128'(cnt));
         chk($sformatf("%s_k%0d_full", tag, k), {127'b0, of}, {127'b0, cnt == dep[k]});
      end
   endtask

   task automatic step(input string tag, input logic e, input logic f, input logic v,
                       input logic [7:0] a8, input logic [127:0] a128);
      en = e; flush = f; vld_in = v; d8 = a8; d128 = a128;
      @(posedge eph1);
      model_edge();
      #1;
      check_all(tag);
   endtask

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   initial begin
      reset = 1'b1; en = 1'b1; flush = 1'b0; vld_in = 1'b0; d8 = 8'h00; d128 = '0;
      // async reset before any clock edge
      #1 reset = 1'b0;
      #1;
      model_clear();
      check_all("rst_pre_edge");
      chk("rst_q4_resetval", {120'b0, q4}, 128'h3C);

      // reset held across edges ignores en/d
      step("rst_hold", 1'b1, 1'b0, 1'b1, 8'h77, 128'h77);
      reset = 1'b1;

      // single plain register: q follows d one edge later
      step("d1_a5", 1'b1, 1'b0, 1'b1, 8'hA5, 128'hA5);
      chk("d1_q_a5", {120'b0, q1}, 128'hA5);

      // 128x12 fill with 1..12
      for (int i = 1; i <= 12; i++)
         step("fill", 1'b1, 1'b0, 1'b1, 8'(i), 128'(i));
      chk("w12_q_is_1", q12, 128'd1);
      chk("w12_tap0_is_12", taps12[127:0], 128'd12);
      chk("w12_full", {127'b0, full12}, 128'd1);
      chk("w12_count", {124'b0, vc12}, 128'd12);

      // full pipeline holds with en=0 while d changes
      for (int i = 0; i < 3; i++)
         step("hold", 1'b0, 1'b0, 1'($urandom), 8'($urandom), rnd128());
      chk("d4_hold_full", {127'b0, full4}, 128'd1);

      // flush beats en; FF not captured
      step("flush", 1'b1, 1'b1, 1'b1, 8'hFF, {16{8'hFF}});
      chk("d4_flush_tap0", {120'b0, taps4[7:0]}, 128'h3C);
      chk("d4_flush_count", {125'b0, vc4}, 128'd0);

      // fill d4 then pulse reset between edges
      for (int i = 0; i < 4; i++)
         step("refill", 1'b1, 1'b0, 1'b1, 8'($urandom), rnd128());
      reset = 1'b0;
      #1;
      model_clear();
      check_all("rst_mid");
      chk("rst_mid_vo4", {127'b0, vo4}, 128'd0);
      reset = 1'b1;
      #1;
      for (int i = 0; i < 4; i++) begin
         step("post_rst", 1'b1, 1'b0, 1'b1, 8'($urandom), rnd128());
         chk($sformatf("post_rst_vo4_%0d", i), {127'b0, vo4}, {127'b0, i == 3});
      end

      // randomized traffic, occasional flush and mid-cycle reset
      for (int n = 0; n < 200; n++) begin
         step("rand", ($urandom_range(3) != 0), ($urandom_range(15) == 0),
              1'($urandom), 8'($urandom), rnd128());
         if ($urandom_range(31) == 0) begin
            reset = 1'b0;
            #1;
            model_clear();
            check_all("rand_rst");
            reset = 1'b1;
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/rregs_pipe.md
# rregs_pipe

Parameterised register pipeline: a chain of DEPTH clocked registers of WIDTH bits, all tapped, with per-stage valid tracking. It is the generic storage primitive behind register chains such as the AES round-key store, where one value enters per cycle and every stage is read in parallel. With DEPTH=1 and `en` tied high it behaves as a single plain register (`q` follows `d` one cycle later).

## Interface
- WIDTH, 1: data width of each stage, ≥1.
- DEPTH, 1: number of stages, ≥1; DEPTH=0 is an elaboration error.
- RESET_VAL, '0 (WIDTH bits): value loaded into every stage on reset and flush.
- eph1  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = asserted), applied immediately.
- en  in  1  shift enable; 0 holds all state.
- flush  in  1  synchronous clear of all stages and valids.
- d  in  WIDTH  data into stage 0.
- vld_in  in  1  qualifies `d`.
- q  out  WIDTH  last stage, stage[DEPTH-1].
- taps  out  DEPTH*WIDTH  all stages; taps[i*WIDTH +: WIDTH] = stage[i], stage 0 least significant.
- vld_out  out  1  valid bit of last stage.
- vld_count  out  $clog2(DEPTH+1)  number of stages currently valid.
- full  out  1  all DEPTH valid bits set.

## Operation
- Per rising edge, priority order: reset (async) > flush > en > hold.
- reset=0: every stage = RESET_VAL, every valid = 0, vld_count = 0, full = 0, without waiting for a clock edge; held while reset=0.
- flush=1 (reset=1): same clear on the edge, regardless of `en`.
- en=1: stage[0] <= d, valid[0] <= vld_in; stage[i] <= stage[i-1], valid[i] <= valid[i-1] for i≥1; stage[DEPTH-1] content is discarded.
- en=0: all stages and valids hold.
- Data moves regardless of valid; valid only labels it. Invalid stages keep whatever data was shifted in.
- vld_count = popcount of valid bits; full = (vld_count == DEPTH). Both combinational from registered valids.
- All outputs are direct register outputs or pure combinational functions of them; no path from d/vld_in to any output in the same cycle.

## Timing
- Latency d -> q: DEPTH enabled edges; d -> taps stage i: i+1 enabled edges.
- After reset release, the first capture is on the first rising edge with reset=1; no synchronous release logic inside the block.
- Reset asserted mid-stream: outputs go to reset values within the same cycle; data in flight is lost.
- Simultaneous flush and en: flush wins; `d` that cycle is dropped.
- vld_count saturates naturally at DEPTH; when full and en=1 with vld_in=1 it stays DEPTH.
- DEPTH=1: q = stage[0], taps = q, full = vld_out.

## Structure
- One sub-module `rregs_stage`: single WIDTH-bit register with async active-low reset to RESET_VAL, synchronous clear, and enable; instantiated DEPTH times via generate, plus a 1-bit instance per stage for the valid chain.
- popcount for vld_count in a function local to rregs_pipe.
- No shared package needed; RESET_VAL is a per-instance parameter.

## Test plan
- WIDTH=8, DEPTH=1, en=1: reset=0 then 1, d=8'hA5 -> q=8'h00 during reset, q=8'hA5 one edge after d applied.
- WIDTH=128, DEPTH=12, en=1, vld_in=1, d = 1,2,...,12 on successive edges -> after 12 edges taps stage 11..0 = 1..12, q=1, full=1, vld_count=12.
- WIDTH=11, RESET_VAL=11'h001: reset low -> q=11'h001 immediately, before any eph1 edge.
- DEPTH=4, pipeline full, en=0 for 3 edges while d changes -> taps, valids, vld_count unchanged.
- DEPTH=4, flush=1 and en=1 same edge with d=8'hFF -> all stages RESET_VAL, vld_count=0, 8'hFF not captured.
- DEPTH=4, reset pulsed low between edges with pipeline full -> all outputs cleared mid-cycle, vld_out=0, refill requires 4 enabled edges.
